regfile_dump_reader: RTL and testbench

- Read-side initiator for the 16 x 16-bit dual-read register file.
- Drives both read address ports (A, B) to fetch two registers per access, buffers them, and streams them one word at a time over a valid/ready interface.
- Serves the debug/UART dump path and the context-save path.
- Raises busy so the datapath controller holds off register-file writes during a scan.

---
 rtl/regfile_dump_reader_pkg.sv | 18 +
 rtl/regfile_dump_reader_dump_word_counter.sv | 58 +++++
 rtl/regfile_dump_reader.sv | 187 ++++++++++++++++++
 tb/tb_regfile_dump_reader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: default widths,
// register count and the scan FSM state encoding.
package regfile_dump_reader_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;
    localparam int NUM_REGS   = 16;

    // SEND_SUM is only reachable when REGFILE_DUMP_CHECKSUM_EN is defined
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        SEND_A   = 3'd2,
        SEND_B   = 3'd3,
        SEND_SUM = 3'd4
    } state_e;

endpackage

// File: rtl/regfile_dump_reader_dump_word_counter.sv
// Scan position tracker for the dump reader: holds the current pair index and
// the number of words still to stream, with modulo-16 wrap arithmetic.
module dump_word_counter
    import regfile_dump_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              dec,
    input  logic              adv,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] next_idx,
    output logic              is_last
);

    localparam int CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [ADDR_W-1:0] span;

    // The span wraps naturally in ADDR_W bits, so first > last counts through 15->0
    assign span     = last_reg - first_reg;
    assign next_idx = idx_q + ADDR_W'(2);
    assign is_last  = (remaining_q == CNT_W'(1));

    // Load on an accepted start, otherwise step down per word and advance per pair
    always_comb begin
        idx_d       = idx_q;
        remaining_d = remaining_q;
        if (load) begin
            idx_d       = first_reg;
            remaining_d = {1'b0, span} + CNT_W'(1);
        end else begin
            if (dec) begin
                remaining_d = remaining_q - CNT_W'(1);
            end
            if (adv) begin
                idx_d = next_idx;
            end
        end
    end

    // Counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q       <= '0;
            remaining_q <= '0;
        end else begin
            idx_q       <= idx_d;
            remaining_q <= remaining_d;
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: fetches two registers per access over the A/B
// read ports and streams them one word at a time on a valid/ready interface.
// Optional feature macro: REGFILE_DUMP_CHECKSUM_EN appends a 16-bit sum word.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [DATA_W-1:0] rd_data_a,
    input  logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam state_e AFTER_LAST  = SEND_SUM;
    localparam logic   LAST_ON_REG = 1'b0;
`else
    localparam state_e AFTER_LAST  = IDLE;
    localparam logic   LAST_ON_REG = 1'b1;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_a_q, rd_addr_a_d;
    logic [ADDR_W-1:0] rd_addr_b_q, rd_addr_b_d;
    logic [DATA_W-1:0] buf_a_q, buf_a_d;
    logic [DATA_W-1:0] buf_b_q, buf_b_d;
    logic              done_q, done_d;

    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_adv;
    logic [ADDR_W-1:0] next_idx;
    logic              is_last;

`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
`endif

    dump_word_counter #(
        .ADDR_W(ADDR_W)
    ) u_counter (
        .clk       (clk),
        .reset     (reset),
        .load      (cnt_load),
        .dec       (cnt_dec),
        .adv       (cnt_adv),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .next_idx  (next_idx),
        .is_last   (is_last)
    );

    assign rd_addr_a = rd_addr_a_q;
    assign rd_addr_b = rd_addr_b_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    // Next-state, address, buffer and stream-output logic for the scan FSM
    always_comb begin
        state_d     = state_q;
        rd_addr_a_d = rd_addr_a_q;
        rd_addr_b_d = rd_addr_b_q;
        buf_a_d     = buf_a_q;
        buf_b_d     = buf_b_q;
        done_d      = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        cnt_adv     = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_load    = 1'b1;
                    rd_addr_a_d = first_reg;
                    rd_addr_b_d = first_reg + ADDR_W'(1);
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                buf_a_d = rd_data_a;
                buf_b_d = rd_data_b;
                state_d = SEND_A;
            end
            SEND_A: begin
                out_valid = 1'b1;
                out_data  = buf_a_q;
                out_last  = LAST_ON_REG & is_last;
                if (out_ready) begin
                    cnt_dec = 1'b1;
                    if (is_last) begin
                        state_d = AFTER_LAST;
                        done_d  = (AFTER_LAST == IDLE);
                    end else begin
                        state_d = SEND_B;
                    end
                end
            end
            SEND_B: begin
                out_valid = 1'b1;
                out_data  = buf_b_q;
                out_last  = LAST_ON_REG & is_last;
                if (out_ready) begin
                    cnt_dec = 1'b1;
                    cnt_adv = 1'b1;
                    if (is_last) begin
                        state_d = AFTER_LAST;
                        done_d  = (AFTER_LAST == IDLE);
                    end else begin
                        rd_addr_a_d = next_idx;
                        rd_addr_b_d = next_idx + ADDR_W'(1);
                        state_d     = FETCH;
                    end
                end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            SEND_SUM: begin
                out_valid = 1'b1;
                out_data  = sum_q;
                out_last  = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, read addresses, fetch buffers and done pulse registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            buf_a_q     <= '0;
            buf_b_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            buf_a_q     <= buf_a_d;
            buf_b_q     <= buf_b_d;
            done_q      <= done_d;
        end
    end

`ifdef REGFILE_DUMP_CHECKSUM_EN
    // Running sum of register words, cleared on each accepted start
    always_comb begin
        sum_d = sum_q;
        if (state_q == IDLE && start) begin
            sum_d = '0;
        end else if (out_valid && out_ready && (state_q == SEND_A || state_q == SEND_B)) begin
            sum_d = sum_q + out_data;
        end
    end

    // Checksum accumulator register
    always_ff @(posedge clk) begin
        if (!reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: directed scans from the test
// plan plus randomized scans with random backpressure, checked against a
// queue-based model of the expected word stream.
module tb_regfile_dump_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  first_reg;
    logic [3:0]  last_reg;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [15:0] regs [16];
    logic [15:0] exp_q [$];

    int vectors;
    int miscompares;

    regfile_dump_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_addr_a"}, 32'(rd_addr_a), 32'd0);
        checkOutput({tag, "_addr_b"}, 32'(rd_addr_b), 32'd0);
        checkOutput({tag, "_data"}, 32'(out_data), 32'd0);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_last"}, 32'(out_last), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic buildExpected(input logic [3:0] f, input logic [3:0] l);
        int n;
        logic [15:0] s;
        exp_q.delete();
        n = ((int'(l) - int'(f) + 16) % 16) + 1;
        s = '0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(regs[(int'(f) + i) % 16]);
            s = s + regs[(int'(f) + i) % 16];
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        exp_q.push_back(s);
`endif
    endtask

    // Runs one scan; returns in the done cycle so a following start lands there.
    task automatic applyStimulus(input logic [3:0] f, input logic [3:0] l, input int stall_word,
                                 input int stall_len, input bit rand_ready, input int abort_after);
        int total;
        int got;
        int stall_left;
        int cycles;
        bit held;
        logic [15:0] held_data;
        logic held_last;

        buildExpected(f, l);
        total      = exp_q.size();
        got        = 0;
        stall_left = stall_len;
        cycles     = 0;
        held       = 1'b0;
        held_data  = '0;
        held_last  = 1'b0;

        first_reg = f;
        last_reg  = l;
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("accept_busy", 32'(busy), 32'd1);
        checkOutput("accept_addr_a", 32'(rd_addr_a), 32'(f));
        checkOutput("accept_addr_b", 32'(rd_addr_b), 32'(4'(f + 4'd1)));
        checkOutput("fetch_valid", 32'(out_valid), 32'd0);
        checkOutput("accept_done", 32'(done), 32'd0);
        tick();
        checkOutput("first_valid", 32'(out_valid), 32'd1);

        while (got < total && cycles < 300) begin
            if (abort_after >= 0 && got == abort_after) begin
                checkOutput("abort_valid", 32'(out_valid), 32'd1);
                checkOutput("abort_data", 32'(out_data), 32'(exp_q[got]));
                reset = 1'b0;
                tick();
                checkIdle("abort_reset");
                reset = 1'b1;
                tick();
                checkIdle("abort_after");
                return;
            end
            if (got == stall_word && stall_left > 0) begin
                out_ready  = 1'b0;
                stall_left--;
            end else begin
                out_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
            end
            if (rand_ready) begin
                start     = ($urandom_range(5) == 0);
                first_reg = 4'($urandom);
                last_reg  = 4'($urandom);
            end
            checkOutput("scan_busy", 32'(busy), 32'd1);
            checkOutput("scan_done", 32'(done), 32'd0);
            if (held) begin
                checkOutput("hold_valid", 32'(out_valid), 32'd1);
                checkOutput("hold_data", 32'(out_data), 32'(held_data));
                checkOutput("hold_last", 32'(out_last), 32'(held_last));
            end
            held = 1'b0;
            if (out_valid && out_ready) begin
                checkOutput("word_data", 32'(out_data), 32'(exp_q[got]));
                checkOutput("word_last", 32'(out_last), 32'(got == total - 1));
                got++;
            end else if (out_valid) begin
                held      = 1'b1;
                held_data = out_data;
                held_last = out_last;
            end
            tick();
            cycles++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        checkOutput("word_count", 32'(got), 32'(total));
        checkOutput("end_done", 32'(done), 32'd1);
        checkOutput("end_busy", 32'(busy), 32'd0);
        checkOutput("end_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        start       = 1'b0;
        out_ready   = 1'b1;
        first_reg   = '0;
        last_reg    = '0;
        for (int i = 0; i < 16; i++) begin
            regs[i] = 16'(i) * 16'h1111;
        end

        $display("[TB] reset check");
        repeat (3) tick();
        checkIdle("reset");
        reset = 1'b1;
        tick();
        checkIdle("post_reset");

        $display("[TB] full scan 0..15");
        applyStimulus(4'd0, 4'd15, -1, 0, 1'b0, -1);
        $display("[TB] single register 5");
        applyStimulus(4'd5, 4'd5, -1, 0, 1'b0, -1);
        $display("[TB] wrap scan 14..2");
        applyStimulus(4'd14, 4'd2, -1, 0, 1'b0, -1);
        $display("[TB] backpressure on word 3");
        applyStimulus(4'd0, 4'd15, 3, 7, 1'b0, -1);
        $display("[TB] short scan 1..3");
        applyStimulus(4'd1, 4'd3, -1, 0, 1'b0, -1);
        tick();
        $display("[TB] reset during SEND_B");
        applyStimulus(4'd0, 4'd15, -1, 0, 1'b0, 1);
        applyStimulus(4'd7, 4'd12, -1, 0, 1'b0, -1);

        $display("[TB] randomized scans");
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] = 16'($urandom);
            end
            applyStimulus(4'($urandom), 4'($urandom), -1, 0, 1'b1, -1);
        end
        tick();
        checkOutput("final_done", 32'(done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
